// File: rtl/dffsr_ctrl_seq.sv
// dffsr_ctrl_seq: sequences exclusive fixed-width preset/clear pulses with a post-pulse idle gap
module dffsr_ctrl_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 4,
  parameter int GAP_W       = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_valid,
  input  logic       req_kind,
  output logic       req_ready,
  output logic       pre_out,
  output logic       clr_out,
  output logic       rst_sync_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] pulse_count
);
  typedef enum logic [1:0] {RST_HOLD, IDLE, PULSE, GAP} state_t;
  localparam logic [7:0] PW_M1 = 8'(PULSE_W - 1);
  localparam logic [7:0] GW_M1 = 8'(GAP_W > 0 ? GAP_W - 1 : 0);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0] cnt_q, cnt_d, count_q, count_d;
  logic pre_q, pre_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d, fin;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q  <= '0;
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      count_q <= '0;
      pre_q   <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // Last cycle of the pulse (when there is no gap) or of the gap returns to IDLE.
  assign fin = cnt_q == 8'd0 && (state_q == GAP || (state_q == PULSE && GAP_W == 0));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    pre_d   = pre_q;
    clr_d   = clr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      RST_HOLD: state_d = rst_sync_n ? IDLE : RST_HOLD;
      IDLE: if (req_valid) begin
        state_d = PULSE;
        cnt_d   = PW_M1;
        pre_d   = req_kind;
        clr_d   = !req_kind;
        busy_d  = 1'b1;
      end
      PULSE: if (cnt_q == 8'd0) begin
        pre_d   = 1'b0;
        clr_d   = 1'b0;
        state_d = GAP;
        cnt_d   = GW_M1;
      end else cnt_d = cnt_q - 8'd1;
      GAP: cnt_d = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      default: state_d = RST_HOLD;
    endcase
    if (fin) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      count_d = count_q == 8'hff ? count_q : count_q + 8'd1;
    end
  end
  assign req_ready   = state_q == IDLE;
  assign rst_sync_n  = sync_q[SYNC_STAGES-1];
  assign pre_out     = pre_q;
  assign clr_out     = clr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_count = count_q;
  excl_a: assert property (@(posedge clk) disable iff (!clr) !(pre_q && clr_q));
endmodule

// File: tb/tb_dffsr_ctrl_seq.sv
// tb_dffsr_ctrl_seq: directed self-checking bench for dffsr_ctrl_seq (default and fast parameter sets)
module tb_dffsr_ctrl_seq;
  logic clk = 0, clr = 0, req_valid = 0, req_kind = 0, f_valid = 0, f_kind = 0;
  logic req_ready, pre_out, clr_out, rst_sync_n, busy, done;
  logic f_ready, f_pre, f_clr, f_rsn, f_busy, f_done;
  logic [7:0] pulse_count, f_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dffsr_ctrl_seq u_dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_kind(req_kind), .req_ready(req_ready),
    .pre_out(pre_out), .clr_out(clr_out), .rst_sync_n(rst_sync_n), .busy(busy), .done(done),
    .pulse_count(pulse_count)
  );
  dffsr_ctrl_seq #(.SYNC_STAGES(2), .PULSE_W(1), .GAP_W(0)) u_fast (
    .clk(clk), .clr(clr), .req_valid(f_valid), .req_kind(f_kind), .req_ready(f_ready),
    .pre_out(f_pre), .clr_out(f_clr), .rst_sync_n(f_rsn), .busy(f_busy), .done(f_done),
    .pulse_count(f_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // rst_sync_n after edge 2 of release, req_ready after edge 3
  task automatic release_chk();
    @(negedge clk);
    chk("rel1_rsn", rst_sync_n, 0);
    chk("rel1_rdy", req_ready, 0);
    @(negedge clk);
    chk("rel2_rsn", rst_sync_n, 1);
    chk("rel2_rdy", req_ready, 0);
    @(negedge clk);
    chk("rel3_rdy", req_ready, 1);
    chk("rel3_out", {pre_out, clr_out, busy, done, pulse_count}, 0);
  endtask
  task automatic do_reset();
    clr = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_zero", {rst_sync_n, req_ready, pre_out, clr_out, busy, done, pulse_count}, 0);
    end
    clr = 1;
    release_chk();
  endtask
  // held req_valid; kinds[i] is the kind of pulse i; 7-cycle period for PULSE_W=4, GAP_W=2
  task automatic burst(input logic [2:0] kinds, input int n, input int base);
    int idx, ph;
    logic k;
    chk("b_rdy", req_ready, 1);
    req_valid = 1;
    req_kind = kinds[0];
    for (int t = 0; t < 7 * n; t++) begin
      @(negedge clk);
      idx = t / 7;
      ph = t % 7;
      k = kinds[idx];
      if (ph == 0) begin
        if (idx + 1 < n) req_kind = kinds[idx + 1];
        else req_valid = 0;
      end
      chk("b_pre", pre_out, ph < 4 && k);
      chk("b_clr", clr_out, ph < 4 && !k);
      chk("b_busy", busy, ph < 6);
      chk("b_done", done, ph == 6);
      chk("b_rdy", req_ready, ph == 6);
      chk("b_excl", pre_out && clr_out, 0);
      chk("b_cnt", pulse_count, ph == 6 ? base + idx + 1 : base + idx);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    // reset release
    do_reset();
    // single preset pulse
    burst(3'b001, 1, 0);
    @(negedge clk);
    chk("s2_done_low", done, 0);
    chk("s2_cnt", pulse_count, 1);
    // sub-cycle clr glitch still gives a full reset and synchronized release
    #2 clr = 0;
    #1;
    chk("gl_cnt", pulse_count, 0);
    chk("gl_rdy", req_ready, 0);
    chk("gl_rsn", rst_sync_n, 0);
    #1 clr = 1;
    release_chk();
    // request during the gap is ignored
    req_valid = 1;
    req_kind = 0;
    @(negedge clk);
    req_valid = 0;
    repeat (4) @(negedge clk);
    chk("s6_gap_rdy", req_ready, 0);
    chk("s6_gap_busy", busy, 1);
    req_valid = 1;
    req_kind = 1;
    @(negedge clk);
    req_valid = 0;
    chk("s6_out", {pre_out, clr_out}, 0);
    @(negedge clk);
    chk("s6_done", done, 1);
    chk("s6_cnt", pulse_count, 1);
    @(negedge clk);
    chk("s6_noextra", {pre_out, clr_out, busy}, 0);
    chk("s6_rdy", req_ready, 1);
    // back-to-back clear/preset/clear
    do_reset();
    burst(3'b010, 3, 0);
    @(negedge clk);
    chk("s3_cnt", pulse_count, 3);
    chk("s3_idle", {pre_out, clr_out, busy, done}, 0);
    // clr mid clear pulse drops outputs without a clock edge
    req_valid = 1;
    req_kind = 0;
    @(negedge clk);
    req_valid = 0;
    chk("s4_c1", clr_out, 1);
    @(negedge clk);
    chk("s4_c2", clr_out, 1);
    #2 clr = 0;
    #1;
    chk("s4_async", {clr_out, busy, done}, 0);
    chk("s4_cnt", pulse_count, 0);
    do_reset();
    // PULSE_W=1, GAP_W=0: 2-cycle period, saturation after 300 pulses
    chk("f_rdy", f_ready, 1);
    f_valid = 1;
    f_kind = 1;
    for (int t = 0; t <= 600; t++) begin
      @(negedge clk);
      if (t == 598) f_valid = 0;
      if (t == 0) chk("f_t0", {f_pre, f_clr, f_busy, f_done}, 4'b1010);
      if (t == 1) chk("f_t1", {f_pre, f_busy, f_done, f_ready}, 4'b0011);
      if (t == 1) chk("f_t1_cnt", f_cnt, 1);
      if (t == 2) chk("f_t2", {f_pre, f_done}, 2'b10);
      if (t == 507) chk("f_cnt254", f_cnt, 254);
      if (t == 509) chk("f_cnt255", f_cnt, 255);
      if (t == 599) chk("f_sat", {f_done, f_cnt}, 9'h1ff);
      if (t == 600) chk("f_end", {f_pre, f_busy, f_done, f_cnt}, 11'h0ff);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
